uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: OVERSAMPLE, default 16, number of I_baudrate_rx_clk ticks per bit; SHALL be even and at least 4.
REQ-002 Parameter: DATA_BITS, default 8, number of data bits per frame; SHALL be in the range 5..8.
REQ-003 Port: clk  input  1  single system clock; all logic rising-edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: I_baudrate_rx_clk  input  1  one-clk-wide oversample tick from baudrate_gen, at OVERSAMPLE times the baud rate.
REQ-006 Port: I_rx_en  input  1  receiver enable.
REQ-007 Port: I_rx  input  1  asynchronous serial line, idle high.
REQ-008 Port: O_rx_data  output  DATA_BITS  last received word, LSB first on line.
REQ-009 Port: O_rx_valid  output  1  one-clk pulse, good frame.
REQ-010 Port: O_rx_frame_err  output  1  one-clk pulse, stop bit sampled low.
REQ-011 Port: O_rx_busy  output  1  high in any state other than IDLE.

Function
REQ-012 I_rx SHALL pass through a 2-flop synchronizer (reset value 1) before any use.
REQ-013 FSM states: IDLE, START, DATA, PARITY (only when the macro is defined), STOP, BREAK.
REQ-014 Counters (tick_cnt, bit_cnt) SHALL advance only on clk cycles where I_baudrate_rx_clk=1.
REQ-015 IDLE->START: tick with I_rx_en=1 and synced rx=0; tick_cnt cleared.
REQ-016 START: on the tick where tick_cnt reaches OVERSAMPLE/2-1, rx=0 -> DATA with counters cleared; rx=1 -> IDLE (false start, no pulses).
REQ-017 DATA: every OVERSAMPLE ticks, sample rx into a shift register, LSB first; after DATA_BITS samples -> PARITY or STOP.
REQ-018 STOP: after OVERSAMPLE ticks, sample rx.
REQ-019 STOP sample=1: O_rx_data loads the shift register, O_rx_valid=1 for exactly one clk on the following clk edge, -> IDLE.
REQ-020 STOP sample=0: O_rx_data loads the shift register, O_rx_frame_err=1 for one clk, O_rx_valid stays 0, -> BREAK.
REQ-021 BREAK: remain until a tick with synced rx=1, then -> IDLE; no start detection while in BREAK.
REQ-022 I_rx_en=0 in any non-IDLE state SHALL abort to IDLE on the next clk, with no pulses and O_rx_data unchanged.
REQ-023 O_rx_data SHALL hold its value between frames; ticks arriving while in IDLE with rx=1 have no effect.
REQ-024 Ticks SHALL be treated as independent of the pulse outputs; a tick coinciding with an output pulse is not lost.

Reset
REQ-025 rst=1 SHALL force, on the next clk edge: state=IDLE, counters=0, shift register=0, synchronizer=1, O_rx_data=0, O_rx_valid=0, O_rx_frame_err=0, O_rx_busy=0.
REQ-026 Reset mid-frame SHALL discard the frame; reception resumes with the first start bit after rst=0.

Configuration
REQ-027 Macro: UART_RX_PARITY_EN.
REQ-028 When defined: the PARITY state samples one even-parity bit after the data bits, and output port O_rx_parity_err (1 bit) is added.
REQ-029 When defined and parity mismatches with a good stop bit: O_rx_parity_err pulses for one clk in place of O_rx_valid, and O_rx_data is still updated.
REQ-030 When undefined: there is no PARITY state and no O_rx_parity_err port; the frame is 8N1.

Verification
REQ-031 Bench settings: OVERSAMPLE=16, tick every 4 clk.
REQ-032 Receive 0xA5 as 8N1 -> O_rx_valid one pulse, O_rx_data=0xA5, O_rx_busy low afterwards.
REQ-033 Receive back-to-back 0x00 then 0xFF with no idle gap -> two valid pulses, data 0x00 then 0xFF.
REQ-034 Apply a 4-tick low glitch on I_rx -> no pulses, return to IDLE, O_rx_data unchanged.
REQ-035 Send 0x3C with stop bit=0, then hold the line low for 20 ticks -> one frame_err pulse, O_rx_data=0x3C, no new frame until the line returns high.
REQ-036 Assert rst, then separately drop I_rx_en, in the middle of bit 3 of 0x5A -> no pulses, state IDLE, a following 0x81 is received correctly.
REQ-037 With UART_RX_PARITY_EN defined: 0x07 with parity bit=0 -> O_rx_parity_err pulse, no valid pulse; 0x07 with parity bit=1 -> O_rx_valid pulse.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, DATA_BITS data bits LSB first, one stop bit.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data and the O_rx_parity_err output.
module uart_rx #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 I_baudrate_rx_clk,
   input  logic                 I_rx_en,
   input  logic                 I_rx,
   output logic [DATA_BITS-1:0] O_rx_data,
   output logic                 O_rx_valid,
   output logic                 O_rx_frame_err,
`ifdef UART_RX_PARITY_EN
   output logic                 O_rx_parity_err,
`endif
   output logic                 O_rx_busy
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      BREAK
   } state_t;

   state_t               state_q;
   logic                 rx_meta_q, rx_sync_q;
   logic [TW-1:0]        tick_cnt_q;
   logic [3:0]           bit_cnt_q;
   logic [DATA_BITS-1:0] shift_q, data_q;
   logic                 valid_q, ferr_q;
   logic                 full;
`ifdef UART_RX_PARITY_EN
   logic                 par_q, perr_q;
   assign O_rx_parity_err = perr_q;
`endif

   assign full           = tick_cnt_q == FULL;
   assign O_rx_data      = data_q;
   assign O_rx_valid     = valid_q;
   assign O_rx_frame_err = ferr_q;
   assign O_rx_busy      = state_q != IDLE;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q      <= 1'b0;
         perr_q     <= 1'b0;
`endif
      end else begin
         rx_meta_q <= I_rx;
         rx_sync_q <= rx_meta_q;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q    <= 1'b0;
`endif
         // Disabling the receiver drops any frame in progress without touching the outputs
         if (state_q != IDLE && !I_rx_en) state_q <= IDLE;
         else if (I_baudrate_rx_clk) begin
            case (state_q)
               IDLE: if (I_rx_en && !rx_sync_q) begin
                  state_q    <= START;
                  tick_cnt_q <= '0;
               end
               START: if (tick_cnt_q == HALF) begin
                  state_q    <= rx_sync_q ? IDLE : DATA;
                  tick_cnt_q <= '0;
                  bit_cnt_q  <= '0;
               end else tick_cnt_q <= tick_cnt_q + 1'b1;
               DATA: begin
                  tick_cnt_q <= full ? '0 : tick_cnt_q + 1'b1;
                  if (full) begin
                     shift_q   <= {rx_sync_q, shift_q[DATA_BITS-1:1]};
                     bit_cnt_q <= bit_cnt_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                     if (bit_cnt_q == 4'(DATA_BITS - 1)) state_q <= PARITY;
`else
                     if (bit_cnt_q == 4'(DATA_BITS - 1)) state_q <= STOP;
`endif
                  end
               end
`ifdef UART_RX_PARITY_EN
               PARITY: begin
                  tick_cnt_q <= full ? '0 : tick_cnt_q + 1'b1;
                  if (full) begin
                     par_q   <= rx_sync_q;
                     state_q <= STOP;
                  end
               end
`endif
               STOP: begin
                  tick_cnt_q <= full ? '0 : tick_cnt_q + 1'b1;
                  if (full) begin
                     data_q  <= shift_q;
                     state_q <= rx_sync_q ? IDLE : BREAK;
                     ferr_q  <= !rx_sync_q;
`ifdef UART_RX_PARITY_EN
                     valid_q <= rx_sync_q && (par_q == ^shift_q);
                     perr_q  <= rx_sync_q && (par_q != ^shift_q);
`else
                     valid_q <= rx_sync_q;
`endif
                  end
               end
               BREAK: if (rx_sync_q) state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end
endmodule
